// File: rtl/baudrate_gen_prog.sv
// Programmable fractional baud-rate generator: oversample tick plus TX bit and RX mid-bit strobes.
// One clock from internal tick to strobe; no backpressure, strobes are free-running pulses.
module baudrate_gen_prog #(
  parameter int DIV_W    = 16,
  parameter int OSR      = 16,
  parameter int DEF_DIV  = 65,
  parameter int DEF_FRAC = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic [DIV_W-1:0] cfg_div,
  input  logic [3:0]       cfg_frac,
  input  logic             cfg_load,
  input  logic             tx_en,
  input  logic             rx_en,
  input  logic             rx_sync,
  output logic             os_stb,
  output logic             tx_br_stb,
  output logic             rx_br_stb,
  output logic             cfg_err
);

  localparam int CNT_W = $clog2(OSR);

  logic [DIV_W-1:0] cur_div;
  logic [3:0]       cur_frac;
  logic [DIV_W-1:0] div_cnt;
  logic [3:0]       frac_acc;
  logic             ext;
  logic [CNT_W-1:0] tx_cnt;
  logic [CNT_W-1:0] rx_cnt;

  logic [DIV_W-1:0] eff_div;
  logic [DIV_W:0]   tick_at;
  logic [4:0]       frac_sum;
  logic             tick;

  // ext stretches the current period by one clock whenever the fractional accumulator carried
  always_comb begin
    eff_div  = (cur_div < DIV_W'(2)) ? DIV_W'(2) : cur_div;
    tick_at  = {1'b0, eff_div} + (DIV_W+1)'(ext) - (DIV_W+1)'(1);
    tick     = ({1'b0, div_cnt} == tick_at);
    frac_sum = {1'b0, frac_acc} + {1'b0, cur_frac};
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      cur_div   <= DIV_W'(DEF_DIV);
      cur_frac  <= 4'(DEF_FRAC);
      cfg_err   <= (DEF_DIV < 2);
      div_cnt   <= '0;
      frac_acc  <= '0;
      ext       <= 1'b0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      os_stb    <= 1'b0;
      tx_br_stb <= 1'b0;
      rx_br_stb <= 1'b0;
    end else if (cfg_load) begin
      cur_div   <= cfg_div;
      cur_frac  <= cfg_frac;
      cfg_err   <= (cfg_div < DIV_W'(2));
      div_cnt   <= '0;
      frac_acc  <= '0;
      ext       <= 1'b0;
      tx_cnt    <= '0;
      rx_cnt    <= '0;
      os_stb    <= 1'b0;
      tx_br_stb <= 1'b0;
      rx_br_stb <= 1'b0;
    end else begin
      if (tick) begin
        div_cnt         <= '0;
        {ext, frac_acc} <= frac_sum;
      end else begin
        div_cnt <= div_cnt + DIV_W'(1);
      end

      if (!tx_en)    tx_cnt <= '0;
      else if (tick) tx_cnt <= tx_cnt + CNT_W'(1);

      // rx_sync restarts the bit phase; the coincident tick is deliberately not counted
      if (!rx_en)       rx_cnt <= '0;
      else if (rx_sync) rx_cnt <= '0;
      else if (tick)    rx_cnt <= rx_cnt + CNT_W'(1);

      os_stb    <= tick;
      tx_br_stb <= tick & tx_en & (tx_cnt == CNT_W'(OSR-1));
      rx_br_stb <= tick & rx_en & ~rx_sync & (rx_cnt == CNT_W'(OSR/2-1));
    end
  end

endmodule
